mtimer_multi: RTL and testbench
===============================

Name: mtimer_multi

Overview:
- Parametrised machine-timer block, successor to the single-channel mtime/mtimecmp logic inside the CSR unit.
- Provides:
  - a prescaled free-running counter of width CNT_WIDTH;
  - NUM_CMP independent compare channels, each with sticky pending and enable bits;
  - torn-read-safe 32-bit memory-mapped access to the wide registers.
- Sits on the data-memory bus beside the core. irq_any_o feeds the MTIP input of the CSR unit.

Parameters:
- NUM_CMP, 2, number of compare channels (1..8)
- CNT_WIDTH, 64, counter and compare width (33..64)
- PRESCALE_WIDTH, 8, prescaler reload register width (1..32)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req_valid_i  in  1  bus access strobe, one cycle per access
- req_we_i  in  1  1 = write, 0 = read
- req_addr_i  in  6  word offset within the block
- req_wdata_i  in  32  write data
- rsp_valid_o  out  1  read/write acknowledge
- rsp_rdata_o  out  32  read data, valid with rsp_valid_o
- irq_o  out  NUM_CMP  per-channel interrupt, pending & enable
- irq_any_o  out  1  OR of irq_o
- mtime_o  out  CNT_WIDTH  current counter value

Behaviour:
- Clocking: one clock domain (clk). Reset is synchronous, active-high (rst), sampled on posedge clk.
- Register map (word offsets):
  - 0 MTIME_LO
  - 1 MTIME_HI
  - 2 PRESCALE
  - 3 CTRL (bit0 = count enable)
  - 4 IRQ_PEND (write-1-to-clear)
  - 5 IRQ_EN
  - 8+2k CMPk_LO, 9+2k CMPk_HI, for k < NUM_CMP
  - All other offsets: read 0, writes ignored, still acknowledged.
- Reset values:
  - mtime 0, prescale counter 0, PRESCALE 0, CTRL.enable 1
  - IRQ_PEND 0, IRQ_EN 0
  - every CMPk all-ones, so no spurious compare match out of reset
  - rsp_valid_o 0, rsp_rdata_o 0, irq_o 0, irq_any_o 0
- Bus timing:
  - rsp_valid_o is asserted exactly one cycle after req_valid_i, for one cycle.
  - rsp_rdata_o is registered and held at 0 when rsp_valid_o is low.
  - Back-to-back requests are accepted every cycle; there is no stall.
- Wide fields:
  - HI words map bits CNT_WIDTH-1:32.
  - Unused upper bits read 0 and ignore writes.
  - IRQ_PEND and IRQ_EN use bits NUM_CMP-1:0; other bits read 0.
- Atomic read:
  - A read of MTIME_LO captures mtime[CNT_WIDTH-1:32] into a shadow register in the same cycle.
  - A subsequent read of MTIME_HI returns the shadow, not the live value.
  - Shadow reset value is 0.
- Prescaler:
  - When CTRL.enable=1, the prescale counter decrements each cycle.
  - When it equals 0, mtime increments by 1 and the counter reloads from PRESCALE.
  - PRESCALE=0 therefore gives one increment per cycle; PRESCALE=N gives one per N+1 cycles.
  - When CTRL.enable=0, both the counter and mtime hold.
  - Writing PRESCALE reloads the counter with the new value in the same cycle.
- Wrap-around: mtime rolls from all-ones to 0 silently. Wrap alone does not set pending.
- Counter write priority: a write to MTIME_LO/HI replaces that half. The increment is suppressed in that cycle, so the written value appears exactly.
- Compare:
  - Each cycle, for each k, pending[k] is set if registered mtime >= registered cmp[k] (unsigned, full CNT_WIDTH).
  - pending[k] is sticky.
- Clearing:
  - A write to CMPk_LO or CMPk_HI clears pending[k].
  - A W1C write to IRQ_PEND clears the selected bits.
  - Clear has priority over set in the same cycle. If the condition still holds, pending re-sets on the following cycle.
- Interrupt outputs:
  - irq_o = pending & IRQ_EN, combinational from registers; no added latency.
  - Masking via IRQ_EN does not clear pending.
- Reset mid-operation: all state returns to its reset value in the reset cycle. A request presented during rst is dropped, with no rsp_valid_o.

Test Plan:
- Reset, then read offset 0 three times, one cycle apart -> rdata 0, then 1, then 2 (PRESCALE=0); rsp_valid_o lags each req by 1 cycle.
- Write PRESCALE=3, then sample mtime_o over 16 cycles -> increments once every 4 cycles; clear CTRL.enable -> mtime_o frozen.
- Write MTIME_LO=0xFFFFFFFE, MTIME_HI=0 -> within 2 cycles mtime crosses 2^32. Read LO returning 0xFFFFFFFF, then HI -> HI returns 0 (shadow), never 1.
- Write CMP1=20 (HI=0, LO=20), IRQ_EN=0b10 -> irq_o[1] and irq_any_o rise in the cycle after mtime reaches 20; irq_o[0] stays 0. Write CMP1_LO=1000 -> irq_o[1] drops next cycle.
- With pending[0] set and mtime still >= CMP0, write IRQ_PEND=0b01 -> pending[0] reads 0 for one cycle, then 1 again. Set IRQ_EN=0 -> irq_o 0 while IRQ_PEND still reads 1.
- Read offset 0x3F and write offset 6 -> rdata 0, acknowledged, no state change. Assert rst mid-burst -> all outputs 0 next cycle, CMPk reads all-ones.

Source files
------------

// File: rtl/mtimer_multi.sv
// mtimer_multi: prescaled free-running machine timer with NUM_CMP compare
// channels and a 32-bit word-addressed register interface. Reading MTIME_LO
// snapshots the upper counter bits so a following MTIME_HI read is
// tear-free. irq_any_o drives the MTIP input of the CSR unit.
module mtimer_multi #(
   parameter int NUM_CMP        = 2,
   parameter int CNT_WIDTH      = 64,
   parameter int PRESCALE_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid_i,
   input  logic                 req_we_i,
   input  logic [5:0]           req_addr_i,
   input  logic [31:0]          req_wdata_i,
   output logic                 rsp_valid_o,
   output logic [31:0]          rsp_rdata_o,
   output logic [NUM_CMP-1:0]   irq_o,
   output logic                 irq_any_o,
   output logic [CNT_WIDTH-1:0] mtime_o
);

   localparam int HI_W = CNT_WIDTH - 32;

   localparam logic [5:0] ADDR_MTIME_LO = 6'd0;
   localparam logic [5:0] ADDR_MTIME_HI = 6'd1;
   localparam logic [5:0] ADDR_PRESCALE = 6'd2;
   localparam logic [5:0] ADDR_CTRL     = 6'd3;
   localparam logic [5:0] ADDR_IRQ_PEND = 6'd4;
   localparam logic [5:0] ADDR_IRQ_EN   = 6'd5;

   localparam logic [CNT_WIDTH-1:0]      CNT_ONE = 1;
   localparam logic [PRESCALE_WIDTH-1:0] PRE_ONE = 1;

   // architectural state
   logic [CNT_WIDTH-1:0]      mtime;
   logic [PRESCALE_WIDTH-1:0] pcnt;
   logic [PRESCALE_WIDTH-1:0] prescale;
   logic                      enable;
   logic [NUM_CMP-1:0]        pending;
   logic [NUM_CMP-1:0]        irq_en;
   logic [CNT_WIDTH-1:0]      cmp [NUM_CMP];
   logic [HI_W-1:0]           shadow;

   // bus decode
   logic wr, rd;
   logic wr_lo, wr_hi, wr_pre, wr_ctrl, wr_pend, wr_en, rd_lo;
   logic [NUM_CMP-1:0] cmp_wr_lo, cmp_wr_hi;
   logic tick;

   // zero-extended views of the narrow fields
   logic [31:0] shadow_word, pre_word, pend_word, en_word, rd_mux;

   assign wr      = req_valid_i & req_we_i;
   assign rd      = req_valid_i & ~req_we_i;
   assign wr_lo   = wr & (req_addr_i == ADDR_MTIME_LO);
   assign wr_hi   = wr & (req_addr_i == ADDR_MTIME_HI);
   assign wr_pre  = wr & (req_addr_i == ADDR_PRESCALE);
   assign wr_ctrl = wr & (req_addr_i == ADDR_CTRL);
   assign wr_pend = wr & (req_addr_i == ADDR_IRQ_PEND);
   assign wr_en   = wr & (req_addr_i == ADDR_IRQ_EN);
   assign rd_lo   = rd & (req_addr_i == ADDR_MTIME_LO);

   // the counter advances only when enabled and the prescaler has run out
   assign tick = enable & (pcnt == '0);

   // per-channel compare register write strobes
   always_comb begin
      cmp_wr_lo = '0;
      cmp_wr_hi = '0;
      for (int k = 0; k < NUM_CMP; k++) begin
         cmp_wr_lo[k] = wr & (req_addr_i == 6'(8 + 2 * k));
         cmp_wr_hi[k] = wr & (req_addr_i == 6'(9 + 2 * k));
      end
   end

   // widen narrow registers to a full bus word with zero upper bits
   always_comb begin
      shadow_word                     = '0;
      shadow_word[HI_W-1:0]           = shadow;
      pre_word                        = '0;
      pre_word[PRESCALE_WIDTH-1:0]    = prescale;
      pend_word                       = '0;
      pend_word[NUM_CMP-1:0]          = pending;
      en_word                         = '0;
      en_word[NUM_CMP-1:0]            = irq_en;
   end

   // read data select; unmapped offsets return 0
   always_comb begin
      rd_mux = '0;
      case (req_addr_i)
         ADDR_MTIME_LO: rd_mux = mtime[31:0];
         ADDR_MTIME_HI: rd_mux = shadow_word;
         ADDR_PRESCALE: rd_mux = pre_word;
         ADDR_CTRL:     rd_mux = {31'd0, enable};
         ADDR_IRQ_PEND: rd_mux = pend_word;
         ADDR_IRQ_EN:   rd_mux = en_word;
         default: begin
            for (int k = 0; k < NUM_CMP; k++) begin
               if (req_addr_i == 6'(8 + 2 * k)) begin
                  rd_mux = cmp[k][31:0];
               end
               if (req_addr_i == 6'(9 + 2 * k)) begin
                  rd_mux          = '0;
                  rd_mux[HI_W-1:0] = cmp[k][CNT_WIDTH-1:32];
               end
            end
         end
      endcase
   end

   // one-cycle acknowledge, registered read data and MTIME_HI snapshot
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid_o <= 1'b0;
         rsp_rdata_o <= '0;
         shadow      <= '0;
      end else begin
         rsp_valid_o <= req_valid_i;
         rsp_rdata_o <= rd ? rd_mux : 32'd0;
         if (rd_lo) begin
            shadow <= mtime[CNT_WIDTH-1:32];
         end
      end
   end

   // prescaler, counter and their control registers; bus writes win over ticks
   always_ff @(posedge clk) begin
      if (rst) begin
         mtime    <= '0;
         pcnt     <= '0;
         prescale <= '0;
         enable   <= 1'b1;
      end else begin
         if (enable) begin
            pcnt <= (pcnt == '0) ? prescale : (pcnt - PRE_ONE);
         end
         if (wr_pre) begin
            prescale <= req_wdata_i[PRESCALE_WIDTH-1:0];
            pcnt     <= req_wdata_i[PRESCALE_WIDTH-1:0];
         end
         if (wr_ctrl) begin
            enable <= req_wdata_i[0];
         end
         if (wr_lo || wr_hi) begin
            if (wr_lo) begin
               mtime[31:0] <= req_wdata_i;
            end
            if (wr_hi) begin
               mtime[CNT_WIDTH-1:32] <= req_wdata_i[HI_W-1:0];
            end
         end else if (tick) begin
            mtime <= mtime + CNT_ONE;
         end
      end
   end

   // compare registers, sticky pending bits (clear beats set) and enables
   always_ff @(posedge clk) begin
      if (rst) begin
         pending <= '0;
         irq_en  <= '0;
         for (int k = 0; k < NUM_CMP; k++) begin
            cmp[k] <= '1;
         end
      end else begin
         for (int k = 0; k < NUM_CMP; k++) begin
            if (cmp_wr_lo[k] || cmp_wr_hi[k] || (wr_pend && req_wdata_i[k])) begin
               pending[k] <= 1'b0;
            end else if (mtime >= cmp[k]) begin
               pending[k] <= 1'b1;
            end
            if (cmp_wr_lo[k]) begin
               cmp[k][31:0] <= req_wdata_i;
            end
            if (cmp_wr_hi[k]) begin
               cmp[k][CNT_WIDTH-1:32] <= req_wdata_i[HI_W-1:0];
            end
         end
         if (wr_en) begin
            irq_en <= req_wdata_i[NUM_CMP-1:0];
         end
      end
   end

   assign irq_o     = pending & irq_en;
   assign irq_any_o = |irq_o;
   assign mtime_o   = mtime;

endmodule

// File: tb/tb_mtimer_multi.sv
// Directed bench for mtimer_multi: a vector table for register access plus
// hand-written sequences for counting, wrap, compare and reset corners.
module tb_mtimer_multi;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_we;
   logic [5:0]  req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic [1:0]  irq;
   logic        irq_any;
   logic [63:0] mtime;

   int n_checks = 0;
   int n_pass   = 0;

   mtimer_multi #(
      .NUM_CMP(2),
      .CNT_WIDTH(64),
      .PRESCALE_WIDTH(8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .req_valid_i(req_valid),
      .req_we_i(req_we),
      .req_addr_i(req_addr),
      .req_wdata_i(req_wdata),
      .rsp_valid_o(rsp_valid),
      .rsp_rdata_o(rsp_rdata),
      .irq_o(irq),
      .irq_any_o(irq_any),
      .mtime_o(mtime)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [5:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic add(input logic we, input logic [5:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp);
      vec_t v;
      v.we = we; v.addr = addr; v.wdata = wdata; v.exp = exp;
      tbl.push_back(v);
   endtask

   // present one request for one cycle; returns at the negedge after acceptance
   task automatic do_req(input logic we, input logic [5:0] addr, input logic [31:0] wdata);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
      @(negedge clk);
      req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
   endtask

   task automatic rd_chk(input string name, input logic [5:0] addr, input logic [31:0] exp);
      do_req(1'b0, addr, 32'd0);
      check({name, "_ack"}, 64'(rsp_valid), 64'd1);
      check(name, 64'(rsp_rdata), 64'(exp));
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] prev;
      logic [63:0] frozen;
      int          last;
      int          incs;

      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
      repeat (3) @(negedge clk);

      // reset state
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst_rdata", 64'(rsp_rdata), 64'd0);
      check("rst_irq", 64'(irq), 64'd0);
      check("rst_irq_any", 64'(irq_any), 64'd0);
      check("rst_mtime", mtime, 64'd0);

      // first reads straight out of reset: 0, 1, 2
      rst = 1'b0;
      rd_chk("mtime_rd0", 6'd0, 32'd0);
      rd_chk("mtime_rd1", 6'd0, 32'd1);
      rd_chk("mtime_rd2", 6'd0, 32'd2);
      @(negedge clk);
      check("idle_rsp_valid", 64'(rsp_valid), 64'd0);
      check("idle_rdata", 64'(rsp_rdata), 64'd0);

      // prescale 3: one increment per 4 cycles
      do_req(1'b1, 6'd2, 32'd3);
      prev = mtime; last = -1; incs = 0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (mtime != prev) begin
            check("presc_step", mtime - prev, 64'd1);
            if (last >= 0) check("presc_interval", 64'(i - last), 64'd4);
            last = i;
            incs++;
            prev = mtime;
         end
      end
      check("presc_incs", 64'(incs), 64'd4);
      do_req(1'b1, 6'd3, 32'd0);
      frozen = mtime;
      repeat (10) @(negedge clk);
      check("disabled_hold", mtime, frozen);

      // register access table
      reset_dut();
      add(1, 6'd3,  32'h0,        32'h0);
      add(0, 6'd3,  32'h0,        32'h0);
      add(0, 6'd2,  32'h0,        32'h0);
      add(1, 6'd2,  32'h1AB,      32'h0);
      add(0, 6'd2,  32'h0,        32'hAB);
      add(0, 6'd8,  32'h0,        32'hFFFFFFFF);
      add(0, 6'd9,  32'h0,        32'hFFFFFFFF);
      add(0, 6'd10, 32'h0,        32'hFFFFFFFF);
      add(0, 6'd11, 32'h0,        32'hFFFFFFFF);
      add(0, 6'd4,  32'h0,        32'h0);
      add(0, 6'd5,  32'h0,        32'h0);
      add(1, 6'd5,  32'hFFFFFFFF, 32'h0);
      add(0, 6'd5,  32'h0,        32'h3);
      add(1, 6'd0,  32'h12345678, 32'h0);
      add(1, 6'd1,  32'hCAFEF00D, 32'h0);
      add(0, 6'd0,  32'h0,        32'h12345678);
      add(0, 6'd1,  32'h0,        32'hCAFEF00D);
      add(0, 6'h3F, 32'h0,        32'h0);
      add(1, 6'd6,  32'hFFFFFFFF, 32'h0);
      add(0, 6'd6,  32'h0,        32'h0);
      add(0, 6'd7,  32'h0,        32'h0);
      add(0, 6'd12, 32'h0,        32'h0);
      add(1, 6'd8,  32'h55,       32'h0);
      add(0, 6'd8,  32'h0,        32'h55);
      add(0, 6'd9,  32'h0,        32'hFFFFFFFF);
      add(1, 6'd4,  32'hFFFFFFFF, 32'h0);
      add(0, 6'd4,  32'h0,        32'h0);
      add(0, 6'd0,  32'h0,        32'h12345678);
      foreach (tbl[i]) begin
         do_req(tbl[i].we, tbl[i].addr, tbl[i].wdata);
         check($sformatf("tbl%0d_ack", i), 64'(rsp_valid), 64'd1);
         if (!tbl[i].we) check($sformatf("tbl%0d_rdata", i), 64'(rsp_rdata), 64'(tbl[i].exp));
      end
      check("tbl_irq", 64'(irq), 64'd0);

      // 2^32 crossing and the MTIME_HI snapshot
      reset_dut();
      do_req(1'b1, 6'd0, 32'hFFFFFFFE);
      do_req(1'b1, 6'd1, 32'd0);
      @(negedge clk);
      rd_chk("wrap_lo", 6'd0, 32'hFFFFFFFF);
      rd_chk("wrap_hi_shadow", 6'd1, 32'd0);
      check("wrap_mtime", mtime, 64'h1_0000_0001);
      rd_chk("wrap_hi_again", 6'd1, 32'd0);
      rd_chk("wrap_lo2", 6'd0, 32'd2);
      rd_chk("wrap_hi_new", 6'd1, 32'd1);

      // compare channel 1 at 20
      reset_dut();
      do_req(1'b1, 6'd11, 32'd0);
      do_req(1'b1, 6'd10, 32'd20);
      do_req(1'b1, 6'd5,  32'd2);
      for (int i = 0; i < 40 && mtime != 64'd20; i++) @(negedge clk);
      check("cmp_reach20", mtime, 64'd20);
      check("cmp_irq_before", 64'(irq), 64'd0);
      @(negedge clk);
      check("cmp_irq_rise", 64'(irq), 64'd2);
      check("cmp_irq_any", 64'(irq_any), 64'd1);
      do_req(1'b1, 6'd10, 32'd1000);
      check("cmp_rewrite_clear", 64'(irq), 64'd0);
      repeat (3) @(negedge clk);
      check("cmp_stays_clear", 64'(irq_any), 64'd0);

      // W1C clear while the condition still holds, then masking
      reset_dut();
      do_req(1'b1, 6'd9, 32'd0);
      do_req(1'b1, 6'd8, 32'd5);
      repeat (10) @(negedge clk);
      rd_chk("pend_set", 6'd4, 32'd1);
      do_req(1'b1, 6'd4, 32'd1);
      rd_chk("pend_cleared", 6'd4, 32'd0);
      rd_chk("pend_reset", 6'd4, 32'd1);
      do_req(1'b1, 6'd5, 32'd1);
      check("en_irq", 64'(irq), 64'd1);
      check("en_irq_any", 64'(irq_any), 64'd1);
      do_req(1'b1, 6'd5, 32'd0);
      check("mask_irq", 64'(irq), 64'd0);
      check("mask_irq_any", 64'(irq_any), 64'd0);
      rd_chk("mask_pend_kept", 6'd4, 32'd1);

      // unmapped access, then reset in the middle of a burst
      do_req(1'b1, 6'd5, 32'd1);
      rd_chk("unmapped_rd", 6'h3F, 32'd0);
      do_req(1'b1, 6'd6, 32'hFFFFFFFF);
      check("unmapped_wr_ack", 64'(rsp_valid), 64'd1);
      rd_chk("unmapped_no_change", 6'd5, 32'd1);
      check("pre_rst_irq", 64'(irq), 64'd1);
      do_req(1'b0, 6'd0, 32'd0);
      do_req(1'b0, 6'd4, 32'd0);
      rst = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 6'd4;
      @(negedge clk);
      req_valid = 1'b0; req_addr = '0;
      check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("midrst_rdata", 64'(rsp_rdata), 64'd0);
      check("midrst_irq", 64'(irq), 64'd0);
      check("midrst_irq_any", 64'(irq_any), 64'd0);
      check("midrst_mtime", mtime, 64'd0);
      rst = 1'b0;
      rd_chk("midrst_cmp0_lo", 6'd8, 32'hFFFFFFFF);
      rd_chk("midrst_cmp0_hi", 6'd9, 32'hFFFFFFFF);
      rd_chk("midrst_cmp1_lo", 6'd10, 32'hFFFFFFFF);
      rd_chk("midrst_cmp1_hi", 6'd11, 32'hFFFFFFFF);
      rd_chk("midrst_en", 6'd5, 32'd0);
      rd_chk("midrst_ctrl", 6'd3, 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
